// File: rtl/screen_sequencer.sv
// Display phase controller: splash, VRAM/OAM clear, play, game-over delay, game-over screen.
// Owns write port A of the background RAM and OAM, muxing clear traffic against engine writes.
module screen_sequencer #(
  parameter int SPLASH_CYCLES     = 500_000_000,
  parameter int OVER_DELAY_CYCLES = 5_000,
  parameter int BG_DEPTH          = 1208,
  parameter int OAM_DEPTH         = 8
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        f_tick,
  input  logic        game_over,
  input  logic        restart,
  input  logic        ge_wea,
  input  logic [15:0] ge_bg_addr,
  input  logic [8:0]  ge_bg_din,
  input  logic [15:0] ge_oam_addr,
  input  logic [31:0] ge_oam_din,
  output logic        bg_wea,
  output logic [15:0] bg_addr,
  output logic [8:0]  bg_din,
  output logic        oam_wea,
  output logic [15:0] oam_addr,
  output logic [31:0] oam_din,
  output logic        engine_clr,
  output logic        game_begin,
  output logic        game_over_display,
  output logic [1:0]  src_sel,
  output logic        cloud_on,
  output logic        busy
);

  localparam logic [31:0] SPLASH_LAST = 32'(SPLASH_CYCLES - 1);
  localparam logic [31:0] OVER_LAST   = 32'(OVER_DELAY_CYCLES - 1);
  localparam logic [15:0] BG_END      = 16'(BG_DEPTH);
  localparam logic [15:0] OAM_END     = 16'(OAM_DEPTH);

  typedef enum logic [2:0] {
    SPLASH,
    CLEAR,
    PLAY,
    OVER_WAIT,
    OVER
  } state_t;

  state_t      state, state_next;
  logic [31:0] counter, counter_next;
  logic [15:0] ca, ca_next;
  logic        restart_q;
  logic        rst_edge;

  assign rst_edge = restart & ~restart_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= SPLASH;
      counter   <= '0;
      ca        <= '0;
      restart_q <= 1'b0;
    end else begin
      state     <= state_next;
      counter   <= counter_next;
      ca        <= ca_next;
      restart_q <= restart;
    end
  end

  always_comb begin
    state_next   = state;
    counter_next = counter;
    ca_next      = ca;
    case (state)
      SPLASH: begin
        counter_next = counter + 32'd1;
        if (counter == SPLASH_LAST || rst_edge) begin
          state_next   = CLEAR;
          counter_next = '0;
          ca_next      = '0;
        end
      end
      CLEAR: begin
        // ca parks at BG_END so the f_tick check only opens after the last write
        if (ca < BG_END) ca_next = ca + 16'd1;
        if (ca == BG_END && f_tick) state_next = PLAY;
      end
      PLAY: begin
        if (game_over) begin
          state_next   = OVER_WAIT;
          counter_next = '0;
        end
      end
      OVER_WAIT: begin
        counter_next = counter + 32'd1;
        if (counter == OVER_LAST) state_next = OVER;
      end
      OVER: begin
        if (rst_edge) begin
          state_next = CLEAR;
          ca_next    = '0;
        end
      end
      default: state_next = SPLASH;
    endcase
  end

  always_comb begin
    bg_wea            = 1'b0;
    bg_addr           = '0;
    bg_din            = '0;
    oam_wea           = 1'b0;
    oam_addr          = '0;
    oam_din           = '0;
    engine_clr        = 1'b1;
    game_begin        = 1'b0;
    game_over_display = 1'b0;
    src_sel           = 2'd0;
    cloud_on          = 1'b0;
    busy              = 1'b0;
    case (state)
      CLEAR: begin
        busy     = 1'b1;
        bg_wea   = (ca < BG_END);
        bg_addr  = ca;
        oam_wea  = (ca < OAM_END);
        oam_addr = ca;
      end
      PLAY: begin
        engine_clr = 1'b0;
        game_begin = 1'b1;
        src_sel    = 2'd1;
        cloud_on   = 1'b1;
        bg_wea     = ge_wea;
        bg_addr    = ge_bg_addr;
        bg_din     = ge_bg_din;
        oam_wea    = ge_wea;
        oam_addr   = ge_oam_addr;
        oam_din    = ge_oam_din;
      end
      OVER_WAIT: begin
        engine_clr = 1'b0;
        game_begin = 1'b1;
        src_sel    = 2'd1;
        cloud_on   = 1'b1;
      end
      OVER: begin
        engine_clr        = 1'b0;
        game_begin        = 1'b1;
        src_sel           = 2'd2;
        game_over_display = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer with shortened phase lengths.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_screen_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic        f_tick;
  logic        game_over;
  logic        restart;
  logic        ge_wea;
  logic [15:0] ge_bg_addr;
  logic [8:0]  ge_bg_din;
  logic [15:0] ge_oam_addr;
  logic [31:0] ge_oam_din;
  logic        bg_wea;
  logic [15:0] bg_addr;
  logic [8:0]  bg_din;
  logic        oam_wea;
  logic [15:0] oam_addr;
  logic [31:0] oam_din;
  logic        engine_clr;
  logic        game_begin;
  logic        game_over_display;
  logic [1:0]  src_sel;
  logic        cloud_on;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  screen_sequencer #(
    .SPLASH_CYCLES(20),
    .OVER_DELAY_CYCLES(5),
    .BG_DEPTH(16),
    .OAM_DEPTH(4)
  ) dut (
    .clk(clk),
    .clr(clr),
    .f_tick(f_tick),
    .game_over(game_over),
    .restart(restart),
    .ge_wea(ge_wea),
    .ge_bg_addr(ge_bg_addr),
    .ge_bg_din(ge_bg_din),
    .ge_oam_addr(ge_oam_addr),
    .ge_oam_din(ge_oam_din),
    .bg_wea(bg_wea),
    .bg_addr(bg_addr),
    .bg_din(bg_din),
    .oam_wea(oam_wea),
    .oam_addr(oam_addr),
    .oam_din(oam_din),
    .engine_clr(engine_clr),
    .game_begin(game_begin),
    .game_over_display(game_over_display),
    .src_sel(src_sel),
    .cloud_on(cloud_on),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wea;
    logic [15:0] bg_a;
    logic [8:0]  bg_d;
    logic [15:0] oam_a;
    logic [31:0] oam_d;
    logic        tick_in;
    logic        restart_in;
    logic        exp_wea;
    logic [15:0] exp_bg_a;
    logic [8:0]  exp_bg_d;
    logic [15:0] exp_oam_a;
    logic [31:0] exp_oam_d;
  } play_vec_t;

  play_vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests_run++;
    if (act !== exp_v) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic apply_stimulus(input play_vec_t v);
    ge_wea      = v.wea;
    ge_bg_addr  = v.bg_a;
    ge_bg_din   = v.bg_d;
    ge_oam_addr = v.oam_a;
    ge_oam_din  = v.oam_d;
    f_tick      = v.tick_in;
    restart     = v.restart_in;
  endtask

  // Drives restart high for the first `hold` cycles of a 40-cycle window and tallies clear activity.
  task automatic observe_clear(input int hold, output int bg_n, output int oam_n, output int rises);
    logic prev;
    bg_n = 0;
    oam_n = 0;
    rises = 0;
    prev = busy;
    for (int i = 0; i < 40; i++) begin
      restart = (i < hold);
      tick();
      if (bg_wea) bg_n++;
      if (oam_wea) oam_n++;
      if (busy && !prev) rises++;
      prev = busy;
    end
  endtask

  task automatic wait_over(output int n);
    n = 0;
    while (src_sel != 2'd2 && n < 50) begin
      check_output("over_wait_bg_wea", 32'(bg_wea), 32'd0);
      check_output("over_wait_oam_wea", 32'(oam_wea), 32'd0);
      check_output("over_wait_bg_addr", 32'(bg_addr), 32'd0);
      tick();
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n, bg_n, oam_n, rises;

    vecs[0] = '{1'b1, 16'h0123, 9'h1AB, 16'h0005, 32'hDEADBEEF, 1'b0, 1'b0,
                1'b1, 16'h0123, 9'h1AB, 16'h0005, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 16'h04B7, 9'h000, 16'h0007, 32'h12345678, 1'b1, 1'b1,
                1'b0, 16'h04B7, 9'h000, 16'h0007, 32'h12345678};
    vecs[2] = '{1'b1, 16'hFFFF, 9'h1FF, 16'hFFFF, 32'hFFFFFFFF, 1'b1, 1'b0,
                1'b1, 16'hFFFF, 9'h1FF, 16'hFFFF, 32'hFFFFFFFF};
    vecs[3] = '{1'b1, 16'h0000, 9'h001, 16'h0003, 32'h00000001, 1'b0, 1'b1,
                1'b1, 16'h0000, 9'h001, 16'h0003, 32'h00000001};

    clr = 1'b0;
    f_tick = 1'b0;
    game_over = 1'b0;
    restart = 1'b0;
    ge_wea = 1'b1;
    ge_bg_addr = 16'h0055;
    ge_bg_din = 9'h0AA;
    ge_oam_addr = 16'h0066;
    ge_oam_din = 32'hCAFE0001;

    // Reset state
    #2;
    check_output("rst_engine_clr", 32'(engine_clr), 32'd1);
    check_output("rst_src_sel", 32'(src_sel), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_game_begin", 32'(game_begin), 32'd0);
    check_output("rst_bg_wea", 32'(bg_wea), 32'd0);
    check_output("rst_oam_din", oam_din, 32'd0);
    tick();
    tick();
    clr = 1'b1;

    // Splash length
    n = 0;
    while (!busy && n < 100) begin
      check_output("splash_src_sel", 32'(src_sel), 32'd0);
      check_output("splash_engine_clr", 32'(engine_clr), 32'd1);
      tick();
      n++;
    end
    check_output("splash_cycles", 32'(n), 32'd20);

    // Clear pass, engine writes dropped, f_tick on final write ignored
    for (int i = 0; i < 16; i++) begin
      check_output("clear_busy", 32'(busy), 32'd1);
      check_output("clear_bg_wea", 32'(bg_wea), 32'd1);
      check_output("clear_bg_addr", 32'(bg_addr), 32'(i));
      check_output("clear_bg_din", 32'(bg_din), 32'd0);
      check_output("clear_oam_wea", 32'(oam_wea), (i < 4) ? 32'd1 : 32'd0);
      check_output("clear_oam_addr", 32'(oam_addr), 32'(i));
      check_output("clear_oam_din", oam_din, 32'd0);
      if (i == 15) f_tick = 1'b1;
      tick();
      f_tick = 1'b0;
    end
    tick();
    check_output("clear_done_busy", 32'(busy), 32'd1);
    check_output("clear_done_bg_wea", 32'(bg_wea), 32'd0);
    check_output("clear_done_engine_clr", 32'(engine_clr), 32'd1);
    f_tick = 1'b1;
    tick();
    f_tick = 1'b0;
    check_output("play_engine_clr", 32'(engine_clr), 32'd0);
    check_output("play_src_sel", 32'(src_sel), 32'd1);
    check_output("play_cloud_on", 32'(cloud_on), 32'd1);
    check_output("play_game_begin", 32'(game_begin), 32'd1);
    check_output("play_busy", 32'(busy), 32'd0);

    // Pass-through table; f_tick and restart must not leave PLAY
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(vecs[i]);
      #1;
      check_output("pt_bg_wea", 32'(bg_wea), 32'(vecs[i].exp_wea));
      check_output("pt_oam_wea", 32'(oam_wea), 32'(vecs[i].exp_wea));
      check_output("pt_bg_addr", 32'(bg_addr), 32'(vecs[i].exp_bg_a));
      check_output("pt_bg_din", 32'(bg_din), 32'(vecs[i].exp_bg_d));
      check_output("pt_oam_addr", 32'(oam_addr), 32'(vecs[i].exp_oam_a));
      check_output("pt_oam_din", oam_din, vecs[i].exp_oam_d);
      tick();
      check_output("pt_stay_play", 32'(src_sel), 32'd1);
      check_output("pt_stay_engine", 32'(engine_clr), 32'd0);
    end
    f_tick = 1'b0;
    restart = 1'b0;
    ge_wea = 1'b1;
    ge_bg_addr = 16'h0123;
    ge_bg_din = 9'h1AB;

    // Game-over path
    game_over = 1'b1;
    tick();
    wait_over(n);
    check_output("over_wait_cycles", 32'(n), 32'd5);
    check_output("over_src_sel", 32'(src_sel), 32'd2);
    check_output("over_display", 32'(game_over_display), 32'd1);
    check_output("over_cloud_on", 32'(cloud_on), 32'd0);
    check_output("over_engine_clr", 32'(engine_clr), 32'd0);
    check_output("over_bg_wea", 32'(bg_wea), 32'd0);
    tick();
    tick();
    check_output("over_holds", 32'(src_sel), 32'd2);

    // Restart held for 10 cycles gives one clear
    observe_clear(10, bg_n, oam_n, rises);
    check_output("restart_clear_entries", 32'(rises), 32'd1);
    check_output("restart_bg_writes", 32'(bg_n), 32'd16);
    check_output("restart_oam_writes", 32'(oam_n), 32'd4);
    check_output("restart_still_clear", 32'(busy), 32'd1);
    f_tick = 1'b1;
    tick();
    f_tick = 1'b0;
    // game_over is still high, so exactly one PLAY cycle precedes OVER_WAIT
    check_output("replay_src_sel", 32'(src_sel), 32'd1);
    check_output("replay_engine_clr", 32'(engine_clr), 32'd0);
    check_output("replay_bg_wea", 32'(bg_wea), 32'd1);
    check_output("replay_bg_addr", 32'(bg_addr), 32'h0123);
    tick();
    check_output("replay_wait_bg_wea", 32'(bg_wea), 32'd0);
    check_output("replay_wait_src_sel", 32'(src_sel), 32'd1);
    game_over = 1'b0;
    wait_over(n);
    check_output("replay_over_wait_cycles", 32'(n), 32'd5);

    // Mid-clear asynchronous reset
    restart = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) tick();
    check_output("midclr_bg_addr", 32'(bg_addr), 32'd7);
    check_output("midclr_bg_wea", 32'(bg_wea), 32'd1);
    #2;
    clr = 1'b0;
    #1;
    check_output("midclr_busy", 32'(busy), 32'd0);
    check_output("midclr_bg_wea_off", 32'(bg_wea), 32'd0);
    check_output("midclr_bg_addr_off", 32'(bg_addr), 32'd0);
    check_output("midclr_oam_wea", 32'(oam_wea), 32'd0);
    check_output("midclr_engine_clr", 32'(engine_clr), 32'd1);
    check_output("midclr_src_sel", 32'(src_sel), 32'd0);
    restart = 1'b0;
    tick();
    tick();
    check_output("midclr_no_writes", 32'(bg_wea), 32'd0);

    // Splash skip by restart edge
    clr = 1'b1;
    tick();
    tick();
    tick();
    check_output("skip_before", 32'(busy), 32'd0);
    restart = 1'b1;
    tick();
    check_output("skip_busy", 32'(busy), 32'd1);
    check_output("skip_bg_addr", 32'(bg_addr), 32'd0);

    // Restart edge on the final splash count
    restart = 1'b0;
    clr = 1'b0;
    tick();
    clr = 1'b1;
    for (int i = 0; i < 19; i++) tick();
    check_output("coincide_before", 32'(busy), 32'd0);
    observe_clear(40, bg_n, oam_n, rises);
    check_output("coincide_entries", 32'(rises), 32'd1);
    check_output("coincide_bg_writes", 32'(bg_n), 32'd16);
    check_output("coincide_oam_writes", 32'(oam_n), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/screen_sequencer.md
# screen_sequencer

Top-level phase controller for the game display. It sequences splash → VRAM clear → play → game-over delay → game-over screen → restart. It drives the background-source select, the layer enables and the game-engine reset. It also owns write port A of the background RAM and the OAM: clear traffic is muxed against game-engine write requests.

## Interface

Parameters:
- SPLASH_CYCLES, 500_000_000, clock cycles the splash is shown after reset
- OVER_DELAY_CYCLES, 5_000, cycles between game_over and game-over screen
- BG_DEPTH, 1208, background RAM words to clear
- OAM_DEPTH, 8, OAM words to clear

Ports:
- clk  in  1  system clock; one clock domain, all logic on posedge clk
- clr  in  1  asynchronous, active-low reset
- f_tick  in  1  one-cycle pulse at frame start
- game_over  in  1  level from game engine
- restart  in  1  level button; rising edge detected internally
- ge_wea  in  1  game-engine write enable, shared by BG and OAM
- ge_bg_addr  in  16  game-engine BG write address
- ge_bg_din  in  9  game-engine BG write data
- ge_oam_addr  in  16  game-engine OAM write address
- ge_oam_din  in  32  game-engine OAM write data
- bg_wea / bg_addr / bg_din  out  1/16/9  BG RAM port A
- oam_wea / oam_addr / oam_din  out  1/16/32  OAM port A
- engine_clr  out  1  active-high reset to game engine
- game_begin  out  1  high when not showing splash
- game_over_display  out  1  game-over screen selected
- src_sel  out  2  background source: 0 splash, 1 bg RAM, 2 game-over RAM
- cloud_on  out  1  cloud layer enable
- busy  out  1  clear in progress

## Operation

- States: SPLASH, CLEAR, PLAY, OVER_WAIT, OVER. Reset enters SPLASH with counter = 0.
- Counters: 32-bit phase counter; 16-bit clear address `ca`.
- Restart edge: rst_edge = restart & ~restart_q, where restart_q is registered and resets to 0.
- SPLASH:
  - counter increments every cycle.
  - At counter == SPLASH_CYCLES-1, or on rst_edge, go to CLEAR with ca = 0.
- CLEAR:
  - bg_wea = (ca < BG_DEPTH), bg_addr = ca, bg_din = 0.
  - oam_wea = (ca < OAM_DEPTH), oam_addr = ca, oam_din = 0.
  - ca increments and saturates at BG_DEPTH.
  - Once ca == BG_DEPTH, the first f_tick moves to PLAY.
  - ge_* inputs are dropped.
- PLAY:
  - Port A is pure pass-through and combinational: bg_wea = oam_wea = ge_wea, and addr/din come from ge_*.
  - game_over = 1 goes to OVER_WAIT with counter = 0.
  - rst_edge and f_tick are ignored.
- OVER_WAIT:
  - Write port idle: wea = 0, addr = 0, din = 0.
  - counter increments; at counter == OVER_DELAY_CYCLES-1, go to OVER.
- OVER:
  - Write port idle.
  - rst_edge goes to CLEAR with ca = 0.
  - game_over is ignored.
- Output decode per state (engine_clr / game_begin / src_sel / cloud_on / game_over_display / busy):
  - SPLASH: 1 / 0 / 0 / 0 / 0 / 0
  - CLEAR: 1 / 0 / 0 / 0 / 0 / 1
  - PLAY: 0 / 1 / 1 / 1 / 0 / 0
  - OVER_WAIT: 0 / 1 / 1 / 1 / 0 / 0
  - OVER: 0 / 1 / 2 / 0 / 1 / 0
- Outside CLEAR and PLAY, port A outputs are all 0.

## Timing

- Reset values:
  - state = SPLASH; counter = 0; ca = 0.
  - All wea/addr/din = 0.
  - engine_clr = 1.
  - game_begin, game_over_display, cloud_on, busy = 0.
  - src_sel = 0.
- Reset is asynchronous, so assertion mid-CLEAR aborts the clear at once with no further writes. Deassertion restarts the full splash.
- Phase durations:
  - SPLASH lasts exactly SPLASH_CYCLES cycles when not skipped.
  - CLEAR writes exactly BG_DEPTH consecutive cycles starting on the first CLEAR cycle, with OAM writes in the first OAM_DEPTH of them.
  - A CLEAR → PLAY transition occurs on the clock edge where f_tick = 1 is sampled with ca == BG_DEPTH. An f_tick during the final write cycle does not count.
  - OVER_WAIT lasts exactly OVER_DELAY_CYCLES cycles.
- State-decoded outputs change on the clock edge entering the new state (Moore). Write pass-through in PLAY has zero latency.
- rst_edge: one cycle from restart rise to state change. Holding restart high does not retrigger.
- A rst_edge coinciding with the final SPLASH count yields a single CLEAR entry.
- game_over already high on entering PLAY moves to OVER_WAIT after one PLAY cycle.

## Test plan

Bench parameters: SPLASH_CYCLES=20, OVER_DELAY_CYCLES=5, BG_DEPTH=16, OAM_DEPTH=4.

- **Reset then idle:** clr low then high → 20 SPLASH cycles with src_sel=0 and engine_clr=1, then busy=1 for 16 cycles.
- **Clear pass:** observe clear → bg_addr 0..15 with bg_wea=1 and din=0; oam_wea high only for addr 0..3. f_tick at clear cycle 15 is ignored; the next f_tick → PLAY with engine_clr=0, src_sel=1, cloud_on=1.
- **PLAY pass-through:** ge_wea=1, ge_bg_addr=0x0123, ge_bg_din=0x1AB → same values on port A in the same cycle.
- **Game-over path:** game_over=1 in PLAY → 5 cycles OVER_WAIT with wea=0, then src_sel=2, game_over_display=1, cloud_on=0.
- **Restart from OVER:** restart held high for 10 cycles → exactly one CLEAR of 16 writes, then PLAY on the next f_tick.
- **Mid-clear reset and splash skip:** clr low at clear cycle 7 → all outputs at reset values at once. rst_edge at splash cycle 3 → CLEAR on the next edge.
